// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, baud divider
// computation and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversampling tick; never below one so the divider always runs.
  function automatic int unsigned calc_div(input int unsigned clock_hz,
                                           input int unsigned baud,
                                           input int unsigned oversampling);
    int unsigned d;
    d = clock_hz / (baud * oversampling);
    return (d == 0) ? 1 : d;
  endfunction

  // Two-of-three vote used to reject single-sample line noise.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, with a
// synchronous clear so the sample phase can be realigned to a start edge.
module uart_rx_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clock,
  input  logic nreset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  // Divider counter; restarts on clear or after reaching DIV-1.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clear || (cnt == CW'(DIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, oversampled start/data/stop FSM
// with majority-vote bit decisions, and a valid/ready output holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BYTESIZES    = 8,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned BAUDRATE     = 115200,
  parameter int unsigned CLOCK_INPUT  = 50_000_000
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 sdata_rx_in,
  input  logic                 ready_rx_in,
  output logic [BYTESIZES-1:0] data_rx_out,
  output logic                 valid_rx_out,
  output logic                 frame_error_out,
  output logic                 overrun_error_out,
  output logic                 busy_rx_out
);

  localparam int unsigned DIV = calc_div(CLOCK_INPUT, BAUDRATE, OVERSAMPLING);
  localparam int unsigned C   = OVERSAMPLING / 2;
  localparam int unsigned SW  = $clog2(OVERSAMPLING);
  localparam int unsigned BW  = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;

  logic                 sync_meta;
  logic                 rx_s;
  logic                 rx_prev;
  rx_state_t            state;
  logic [SW-1:0]        scnt;
  logic [BW-1:0]        bit_idx;
  logic [BYTESIZES-1:0] shreg;
  logic                 samp_a;
  logic                 samp_b;
  logic                 tick;
  logic                 start_edge;
  logic                 at_dec;
  logic                 at_wrap;
  logic                 bit_val;

  // Line synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync_meta <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
    end else begin
      sync_meta <= sdata_rx_in;
      rx_s      <= sync_meta;
      rx_prev   <= rx_s;
    end
  end

  assign start_edge = (state == IDLE) && rx_prev && !rx_s;
  assign at_dec     = tick && (scnt == SW'(C + 1));
  assign at_wrap    = tick && (scnt == SW'(OVERSAMPLING - 1));
  assign bit_val    = majority3(samp_a, samp_b, rx_s);

  uart_rx_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clock (clock),
    .nreset(nreset),
    .clear (start_edge),
    .tick  (tick)
  );

  // Frame FSM with registered outputs and the valid/ready holding register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state             <= IDLE;
      scnt              <= '0;
      bit_idx           <= '0;
      shreg             <= '0;
      samp_a            <= 1'b1;
      samp_b            <= 1'b1;
      data_rx_out       <= '0;
      valid_rx_out      <= 1'b0;
      frame_error_out   <= 1'b0;
      overrun_error_out <= 1'b0;
      busy_rx_out       <= 1'b0;
    end else begin
      frame_error_out   <= 1'b0;
      overrun_error_out <= 1'b0;
      if (valid_rx_out && ready_rx_in) begin
        valid_rx_out <= 1'b0;
      end

      if (tick && (state == START || state == DATA || state == STOP)) begin
        scnt <= at_wrap ? '0 : scnt + SW'(1);
        if (scnt == SW'(C - 1)) samp_a <= rx_s;
        if (scnt == SW'(C))     samp_b <= rx_s;
      end

      // Wrap handling precedes the decision so that, when both land on the
      // same tick (small OVERSAMPLING), a false start still wins.
      case (state)
        IDLE: begin
          if (start_edge) begin
            state       <= START;
            scnt        <= '0;
            bit_idx     <= '0;
            busy_rx_out <= 1'b1;
          end
        end
        START: begin
          if (at_wrap) state <= DATA;
          if (at_dec && bit_val) begin
            state       <= IDLE;
            busy_rx_out <= 1'b0;
          end
        end
        DATA: begin
          if (at_wrap) begin
            if (bit_idx == BW'(BYTESIZES - 1)) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
          if (at_dec) begin
            shreg <= (shreg >> 1) | (BYTESIZES'(bit_val) << (BYTESIZES - 1));
          end
        end
        STOP: begin
          if (at_dec) begin
            if (bit_val) begin
              state       <= IDLE;
              busy_rx_out <= 1'b0;
              if (!valid_rx_out || ready_rx_in) begin
                data_rx_out  <= shreg;
                valid_rx_out <= 1'b1;
              end else begin
                overrun_error_out <= 1'b1;
              end
            end else begin
              frame_error_out <= 1'b1;
              state           <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state       <= IDLE;
            busy_rx_out <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          busy_rx_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, a scoreboard queue of
// expected bytes, and a monitor that checks every accepted byte.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       sdata_rx_in = 1'b1;
  logic       ready_rx_in = 1'b0;
  logic [7:0] data_rx_out;
  logic       valid_rx_out;
  logic       frame_error_out;
  logic       overrun_error_out;
  logic       busy_rx_out;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  uart_rx #(
    .BYTESIZES   (8),
    .OVERSAMPLING(16),
    .BAUDRATE    (100_000),
    .CLOCK_INPUT (1_600_000)
  ) dut (
    .clock            (clock),
    .nreset           (nreset),
    .sdata_rx_in      (sdata_rx_in),
    .ready_rx_in      (ready_rx_in),
    .data_rx_out      (data_rx_out),
    .valid_rx_out     (valid_rx_out),
    .frame_error_out  (frame_error_out),
    .overrun_error_out(overrun_error_out),
    .busy_rx_out      (busy_rx_out)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Advance n clocks; inputs change 1 time unit after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One frame: start, 8 data bits LSB first, stop. spike inverts each data
  // bit for the single clock at its sample centre; stop_low > 0 holds the
  // stop bit low for that many clocks before returning high.
  task automatic send_frame(input logic [7:0] b, input bit spike, input int stop_low);
    sdata_rx_in = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      sdata_rx_in = b[i];
      if (spike) begin
        step(9);
        sdata_rx_in = ~b[i];
        step(1);
        sdata_rx_in = b[i];
        step(6);
      end else begin
        step(16);
      end
    end
    if (stop_low > 0) begin
      sdata_rx_in = 1'b0;
      step(stop_low);
    end
    sdata_rx_in = 1'b1;
    step(16);
  endtask

  // Monitor: counts error pulses and checks each accepted byte against the queue.
  always @(negedge clock) begin
    if (nreset) begin
      if (frame_error_out) fe_cnt++;
      if (overrun_error_out) ov_cnt++;
      if (valid_rx_out && ready_rx_in) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_byte: actual 0x%0h, expected none", data_rx_out);
        end else begin
          check("rx_byte", int'(data_rx_out), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c0;
    int fe0;
    int ov0;

    // Reset values
    step(3);
    check("rst_data", int'(data_rx_out), 0);
    check("rst_valid", int'(valid_rx_out), 0);
    check("rst_ferr", int'(frame_error_out), 0);
    check("rst_oerr", int'(overrun_error_out), 0);
    check("rst_busy", int'(busy_rx_out), 0);
    nreset = 1'b1;
    step(5);

    // Single frame 0xA5, latency and one-cycle valid
    ready_rx_in = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    c0 = cyc;
    fork
      send_frame(8'hA5, 1'b0, 0);
      begin
        int k = 0;
        @(negedge clock);
        while (!valid_rx_out && k < 200) begin
          @(negedge clock);
          k++;
        end
        check("t1_valid_seen", int'(valid_rx_out), 1);
        check_range("t1_latency", cyc - c0, 151, 157);
        @(negedge clock);
        check("t1_valid_one_cycle", int'(valid_rx_out), 0);
      end
    join
    step(10);
    check("t1_ferr_cnt", fe_cnt - fe0, 0);
    check("t1_oerr_cnt", ov_cnt - ov0, 0);

    // Start glitch
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    sdata_rx_in = 1'b0;
    fork
      begin
        step(4);
        sdata_rx_in = 1'b1;
      end
      begin
        int k = 0;
        int n = 0;
        @(negedge clock);
        while (!busy_rx_out && k < 10) begin
          @(negedge clock);
          k++;
        end
        check("t2_busy_rose", int'(busy_rx_out), 1);
        while (busy_rx_out && n < 30) begin
          @(negedge clock);
          n++;
        end
        check_range("t2_busy_drop", n, 1, 12);
      end
    join
    step(20);
    check("t2_ferr_cnt", fe_cnt - fe0, 0);
    check("t2_oerr_cnt", ov_cnt - ov0, 0);
    check("t2_valid", int'(valid_rx_out), 0);

    // Framing error, then a good frame
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 32);
    step(10);
    check("t3_ferr_cnt", fe_cnt - fe0, 1);
    check("t3_valid", int'(valid_rx_out), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 0);
    step(10);
    check("t3_ferr_cnt_after", fe_cnt - fe0, 1);
    check("t3_oerr_cnt", ov_cnt - ov0, 0);
    check("t3_queue_drained", exp_q.size(), 0);

    // Overrun with back-to-back frames
    ready_rx_in = 1'b0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    step(10);
    check("t4_valid_held", int'(valid_rx_out), 1);
    check("t4_data_held", int'(data_rx_out), 8'h11);
    check("t4_oerr_cnt", ov_cnt - ov0, 1);
    ready_rx_in = 1'b1;
    step(1);
    ready_rx_in = 1'b0;
    step(2);
    check("t4_valid_dropped", int'(valid_rx_out), 0);
    check("t4_queue_drained", exp_q.size(), 0);

    // Delivery on the same cycle as acceptance
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b0, 0);
    step(10);
    fork
      send_frame(8'h22, 1'b0, 0);
      begin
        step(156);
        ready_rx_in = 1'b1;
        step(1);
        ready_rx_in = 1'b0;
      end
    join
    step(5);
    check("t5_valid", int'(valid_rx_out), 1);
    check("t5_data", int'(data_rx_out), 8'h22);
    check("t5_oerr_cnt", ov_cnt - ov0, 0);
    ready_rx_in = 1'b1;
    step(1);
    ready_rx_in = 1'b0;
    step(2);
    check("t5_valid_dropped", int'(valid_rx_out), 0);
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset in the middle of data bit 4
    ready_rx_in = 1'b1;
    fork
      send_frame(8'hFF, 1'b0, 0);
      begin
        step(16 * 5 + 8);
        nreset = 1'b0;
        #1;
        check("t6_rst_data", int'(data_rx_out), 0);
        check("t6_rst_valid", int'(valid_rx_out), 0);
        check("t6_rst_ferr", int'(frame_error_out), 0);
        check("t6_rst_oerr", int'(overrun_error_out), 0);
        check("t6_rst_busy", int'(busy_rx_out), 0);
        step(3);
        nreset = 1'b1;
      end
    join
    step(10);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 0);
    step(10);
    check("t6_queue_drained", exp_q.size(), 0);

    // Noise spike at each data bit's sample centre
    fe0 = fe_cnt;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 0);
    step(10);
    check("t7_queue_drained", exp_q.size(), 0);
    check("t7_ferr_cnt", fe_cnt - fe0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
